// File: rtl/axi_wr_burst_sequencer.sv
// axi_wr_burst_sequencer: one-burst-at-a-time AW/W/B feeder with a prefetching data FIFO
module axi_wr_burst_sequencer #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_SIZE = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [2:0]      cmd_size,
  input  logic [1:0]      cmd_burst,
  input  logic [DW-1:0]   s_data,
  input  logic [DW/8-1:0] s_strb,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [AW-1:0]   awaddr_out,
  output logic [7:0]      awlen_out,
  output logic [2:0]      awsize_out,
  output logic [1:0]      awburst_out,
  output logic            awvalid_out,
  output logic [DW-1:0]   wdata_out,
  output logic [DW/8-1:0] wstrb_out,
  output logic            wvalid_out,
  output logic            bready_out,
  input  logic            axi_awvalid,
  input  logic            axi_awready,
  input  logic            axi_wvalid,
  input  logic            axi_wready,
  input  logic            axi_wlast,
  input  logic            axi_bvalid,
  input  logic [1:0]      axi_bresp,
  output logic            done,
  output logic [1:0]      resp,
  output logic            busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, REJECT, ADDR, DATA, RESP} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] mem_data_q [FIFO_DEPTH];
  logic [DW/8-1:0] mem_strb_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0] count_q;
  logic [7:0] beat_q, beat_d;
  logic last_err_q, last_err_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [7:0] awlen_q, awlen_d;
  logic [2:0] awsize_q, awsize_d;
  logic [1:0] awburst_q, awburst_d;
  logic push, w_beat;
  assign s_ready = count_q != (PW+1)'(FIFO_DEPTH);
  assign push = s_valid & s_ready;
  assign wvalid_out = (state_q == DATA) && (count_q != '0);
  assign w_beat = wvalid_out & axi_wvalid & axi_wready;
  assign wdata_out = mem_data_q[rd_ptr_q];
  assign wstrb_out = mem_strb_q[rd_ptr_q];
  assign awvalid_out = state_q == ADDR;
  assign bready_out = state_q == RESP;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign awaddr_out = awaddr_q;
  assign awlen_out = awlen_q;
  assign awsize_out = awsize_q;
  assign awburst_out = awburst_q;
  // FIFO storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= s_data;
      mem_strb_q[wr_ptr_q] <= s_strb;
    end
  end
  // FIFO pointers/count, burst state and latched command
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      state_q <= IDLE;
      beat_q <= '0;
      last_err_q <= 1'b0;
      awaddr_q <= '0;
      awlen_q <= '0;
      awsize_q <= '0;
      awburst_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_beat) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !w_beat) count_q <= count_q + 1'b1;
      else if (!push && w_beat) count_q <= count_q - 1'b1;
      state_q <= state_d;
      beat_q <= beat_d;
      last_err_q <= last_err_d;
      awaddr_q <= awaddr_d;
      awlen_q <= awlen_d;
      awsize_q <= awsize_d;
      awburst_q <= awburst_d;
    end
  end
  // burst sequencing: command check, AW, W beats with wlast audit, B response
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    last_err_d = last_err_q;
    awaddr_d = awaddr_q;
    awlen_d = awlen_q;
    awsize_d = awsize_q;
    awburst_d = awburst_q;
    done = 1'b0;
    resp = 2'b00;
    case (state_q)
      IDLE: if (cmd_valid) begin
        awaddr_d = cmd_addr;
        awlen_d = cmd_len;
        awsize_d = cmd_size;
        awburst_d = cmd_burst;
        state_d = (cmd_size > 3'(MAX_SIZE) || cmd_burst == 2'b11) ? REJECT : ADDR;
      end
      REJECT: begin
        done = 1'b1;
        resp = 2'b10;
        state_d = IDLE;
      end
      ADDR: if (axi_awvalid && axi_awready) begin
        beat_d = awlen_q;
        state_d = DATA;
      end
      DATA: if (w_beat) begin
        beat_d = beat_q - 8'd1;
        if (axi_wlast != (beat_q == '0)) last_err_d = 1'b1;
        if (beat_q == '0) state_d = RESP;
      end
      RESP: if (axi_bvalid) begin
        done = 1'b1;
        resp = (last_err_q && axi_bresp == 2'b00) ? 2'b10 : axi_bresp;
        last_err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_wr_burst_sequencer.sv
// tb_axi_wr_burst_sequencer: randomized bursts checked against a queue-based burst model
module tb_axi_wr_burst_sequencer;
  localparam int FD = 16;
  logic clk = 0, resetn = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [31:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic [2:0] cmd_size = 0;
  logic [1:0] cmd_burst = 0;
  logic [63:0] s_data = 0;
  logic [7:0] s_strb = 0;
  logic s_valid = 0, s_ready;
  logic [31:0] awaddr_out;
  logic [7:0] awlen_out;
  logic [2:0] awsize_out;
  logic [1:0] awburst_out;
  logic awvalid_out, wvalid_out, bready_out;
  logic [63:0] wdata_out;
  logic [7:0] wstrb_out;
  logic axi_awvalid, axi_awready = 0, axi_wvalid, axi_wready = 0, axi_wlast = 0, axi_bvalid = 0;
  logic [1:0] axi_bresp = 0;
  logic done, busy;
  logic [1:0] resp;
  typedef struct packed {logic [63:0] d; logic [7:0] s;} beat_t;
  beat_t q[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int src_left = 0, src_period = 1, wr_mode = 0;
  bit fix_en = 0;
  logic [63:0] fix_d = 0;
  int cur_len = 0, err_beat = -1, wbeats = 0;
  logic [1:0] cur_bresp = 0;
  bit in_data = 0, resp_ph = 0, push_ev, w_ev, aw_ev;
  assign axi_awvalid = awvalid_out;
  assign axi_wvalid = wvalid_out;
  axi_wr_burst_sequencer dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .s_data(s_data), .s_strb(s_strb), .s_valid(s_valid), .s_ready(s_ready),
    .awaddr_out(awaddr_out), .awlen_out(awlen_out), .awsize_out(awsize_out), .awburst_out(awburst_out),
    .awvalid_out(awvalid_out), .wdata_out(wdata_out), .wstrb_out(wstrb_out), .wvalid_out(wvalid_out),
    .bready_out(bready_out), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp),
    .done(done), .resp(resp), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_awvalid", awvalid_out, 0);
    chk("rst_wvalid", wvalid_out, 0);
    chk("rst_bready", bready_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", resp, 0);
    chk("rst_awfields", {awaddr_out, awlen_out, awsize_out, awburst_out}, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
  endtask
  task automatic step();
    @(negedge clk);
    cmd_valid = 0;
    s_valid = src_left > 0 && cyc % src_period == 0;
    s_data = fix_en ? fix_d : {$urandom, $urandom};
    s_strb = fix_en ? 8'hFF : 8'($urandom);
    axi_awready = wr_mode == 0 ? 1'b1 : 1'($urandom);
    axi_wready = wr_mode == 0 ? 1'b1 : wr_mode == 1 ? 1'(cyc % 2) : 1'($urandom);
    axi_wlast = (wbeats == cur_len) != (wbeats == err_beat);
    axi_bvalid = resp_ph && (wr_mode == 0 || $urandom_range(2, 0) == 0);
    axi_bresp = cur_bresp;
    #1;
    chk("s_ready", s_ready, q.size() != FD);
    chk("wvalid", wvalid_out, in_data && q.size() != 0);
    push_ev = s_valid && s_ready;
    w_ev = wvalid_out && axi_wready;
    aw_ev = awvalid_out && axi_awready;
    if (w_ev && q.size() != 0) begin
      chk("wdata", wdata_out, q[0].d);
      chk("wstrb", wstrb_out, q[0].s);
      void'(q.pop_front());
      wbeats++;
    end
    if (push_ev) begin
      q.push_back('{s_data, s_strb});
      src_left--;
    end
    cyc++;
  endtask
  task automatic do_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                          input logic [1:0] b, input int eb, input logic [1:0] br, input int ab);
    bit rej = sz > 3 || b == 2'b11;
    bit aw_done = 0, got_done = 0, aborted = 0;
    int n = 0;
    cur_len = l; err_beat = eb; cur_bresp = br; wbeats = 0; in_data = 0; resp_ph = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_size = sz; cmd_burst = b;
    while (!got_done && !aborted && n < 3000) begin
      step();
      n++;
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("busy", busy, 1);
      if (rej) begin
        chk("rej_done", done, 1);
        chk("rej_resp", resp, 2'b10);
        chk("rej_awvalid", awvalid_out, 0);
        got_done = 1;
      end else begin
        chk("awvalid", awvalid_out, !aw_done);
        chk("bready", bready_out, resp_ph);
        chk("done", done, resp_ph && axi_bvalid);
        if (aw_ev) begin
          chk("awaddr", awaddr_out, a);
          chk("awlen", awlen_out, l);
          chk("awsize", awsize_out, sz);
          chk("awburst", awburst_out, b);
          aw_done = 1;
          in_data = 1;
        end
        if (resp_ph && axi_bvalid) begin
          chk("resp", resp, (br == 2'b00 && eb >= 0 && eb <= int'(l)) ? 2'b10 : br);
          got_done = 1;
          resp_ph = 0;
        end
        if (w_ev && wbeats == int'(l) + 1) begin
          in_data = 0;
          resp_ph = 1;
        end
        if (ab >= 0 && in_data && wbeats == ab) begin
          resetn = 0;
          #1;
          chk_reset_outputs();
          q.delete();
          src_left = 0; s_valid = 0; in_data = 0; resp_ph = 0; wbeats = 0; err_beat = -1;
          @(negedge clk);
          chk("rst_hold_done", done, 0);
          chk("rst_hold_busy", busy, 0);
          resetn = 1;
          aborted = 1;
        end
      end
    end
    if (!got_done && !aborted) chk("burst_timeout", 0, 1);
    if (!aborted) begin
      step();
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
    end
  endtask
  initial begin
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    resetn = 1;
    fix_en = 1; fix_d = 64'hA5A5_0000_0000_0001; src_left = 1; src_period = 1; wr_mode = 0;
    do_burst(32'h1000, 8'd0, 3'd3, 2'b01, -1, 2'b00, -1);
    fix_en = 0;
    src_left = 17; wr_mode = 1;
    repeat (20) step();
    chk("prefetch_full", s_ready, 0);
    src_left = 0;
    do_burst(32'h2000, 8'd15, 3'd3, 2'b01, -1, 2'b00, -1);
    wr_mode = 2;
    do_burst(32'h3000, 8'd3, 3'd4, 2'b01, -1, 2'b00, -1);
    do_burst(32'h3100, 8'd3, 3'd2, 2'b11, -1, 2'b00, -1);
    src_left = 4; src_period = 3;
    do_burst(32'h4000, 8'd3, 3'd3, 2'b01, -1, 2'b00, -1);
    src_left = 4; src_period = 1;
    do_burst(32'h5000, 8'd3, 3'd3, 2'b01, 1, 2'b00, -1);
    src_left = 8; wr_mode = 0;
    do_burst(32'h6000, 8'd7, 3'd3, 2'b01, -1, 2'b00, 3);
    src_left = 3;
    do_burst(32'h7000, 8'd2, 3'd2, 2'b10, -1, 2'b00, -1);
    for (int i = 0; i < 25; i++) begin
      logic [7:0] l = 8'($urandom_range(15, 0));
      logic [2:0] sz = 3'($urandom_range(4, 0));
      logic [1:0] b = 2'($urandom_range(3, 0));
      int need = int'(l) + 1 - q.size();
      src_left = (need > 0 ? need : 0) + $urandom_range(2, 0);
      src_period = $urandom_range(3, 1);
      wr_mode = $urandom_range(2, 0);
      do_burst($urandom, l, sz, b, $urandom_range(3, 0) == 0 ? $urandom_range(int'(l), 0) : -1,
               2'($urandom_range(3, 0)), -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
